// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage.
// Holds the PC, presents it to a zero-latency instruction memory, captures the returned
// word into the IF/ID register and chooses the next PC from halt / branch / jump / stall
// requests issued by later pipeline stages.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        misaligned,
  output logic [1:0]  fetch_state
);

  // Size of the instruction memory in bytes. Computed in 33 bits so that a PC near the
  // top of the address space cannot overflow the sequential-increment comparison.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;
  logic         mis_q, mis_d;

  logic [32:0]  pc_sum;
  logic [31:0]  pc_plus4;
  logic [31:0]  jump_pc;
  logic [31:0]  branch_pc;
  logic         branch_unaligned;

  // Sequential PC with wrap to zero once it runs past the end of instruction memory;
  // the wrapped value feeds both the next PC and the IF/ID pc+4 field.
  always_comb begin
    pc_sum           = {1'b0, pc_q} + 33'd4;
    pc_plus4         = (pc_sum >= MEM_BYTES) ? 32'h0000_0000 : pc_sum[31:0];
    jump_pc          = {pc_plus4[31:28], jump_index, 2'b00};
    branch_pc        = {branch_target[31:2], 2'b00};
    branch_unaligned = (branch_target[1:0] != 2'b00);
  end

  // Next-state and next-PC selection; redirects outrank the hazard stall, and halt
  // outranks everything. BOOT spends exactly one edge doing nothing before RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    mis_d   = mis_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
          instr_d = 32'h0000_0000;
          pcp4_d  = 32'h0000_0000;
          valid_d = 1'b0;
        end else if (branch_taken) begin
          pc_d    = branch_pc;
          instr_d = 32'h0000_0000;
          pcp4_d  = 32'h0000_0000;
          valid_d = 1'b0;
          if (branch_unaligned) begin
            mis_d = 1'b1;
          end
        end else if (jump) begin
          pc_d    = jump_pc;
          instr_d = 32'h0000_0000;
          pcp4_d  = 32'h0000_0000;
          valid_d = 1'b0;
        end else if (stall) begin
          if (flush) begin
            instr_d = 32'h0000_0000;
            pcp4_d  = 32'h0000_0000;
            valid_d = 1'b0;
          end
        end else begin
          pc_d = pc_plus4;
          if (flush) begin
            instr_d = 32'h0000_0000;
            pcp4_d  = 32'h0000_0000;
            valid_d = 1'b0;
          end else begin
            instr_d = imem_data;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
          end
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, PC and IF/ID registers; reset clears them immediately, even mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pcp4_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_addr        = pc_q;
  assign ifid_instruction = instr_q;
  assign ifid_pc_plus4    = pcp4_q;
  assign ifid_valid       = valid_q;
  assign misaligned       = mis_q;
  assign fetch_state      = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized traffic for pc_fetch_unit,
// compared every cycle against a behavioural model of the fetch stage.
module tb_pc_fetch_unit;

  localparam int          MEM_WORDS = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic        halt = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        misaligned;
  logic [1:0]  fetch_state;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .halt(halt),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_instruction(ifid_instruction), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .misaligned(misaligned), .fetch_state(fetch_state)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: word k holds 0x1000_0000 + k.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] idx;
    idx = (addr >> 2) % 32'(MEM_WORDS);
    return 32'h1000_0000 + idx;
  endfunction

  assign imem_data = memWord(imem_addr);

  // Sequential successor of a PC: PC+4, or zero once that reaches the memory size.
  function automatic logic [31:0] seqNext(input logic [31:0] p);
    longint s;
    s = longint'(p) + 64'd4;
    if (s >= longint'(MEM_WORDS) * 4) return 32'h0;
    return 32'(s);
  endfunction

  // Behavioural model: 0 = boot, 1 = run, 2 = halted.
  int          mState;
  logic [31:0] mPc, mInstr, mP4;
  logic        mValid, mMis;

  // Model advance on each edge, reset asynchronously like the stage itself.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mState <= 0; mPc <= RESET_PC; mInstr <= 0; mP4 <= 0; mValid <= 0; mMis <= 0;
    end else if (mState == 0) begin
      mState <= 1;
    end else if (mState == 1) begin
      if (halt) begin
        mState <= 2; mInstr <= 0; mP4 <= 0; mValid <= 0;
      end else if (branch_taken) begin
        mPc <= branch_target & 32'hFFFF_FFFC;
        mInstr <= 0; mP4 <= 0; mValid <= 0;
        if (branch_target % 4 != 0) mMis <= 1'b1;
      end else if (jump) begin
        mPc <= (seqNext(mPc) & 32'hF000_0000) | (32'(jump_index) * 4);
        mInstr <= 0; mP4 <= 0; mValid <= 0;
      end else if (stall) begin
        if (flush) begin mInstr <= 0; mP4 <= 0; mValid <= 0; end
      end else begin
        mPc <= seqNext(mPc);
        if (flush) begin
          mInstr <= 0; mP4 <= 0; mValid <= 0;
        end else begin
          mInstr <= memWord(mPc); mP4 <= seqNext(mPc); mValid <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model imem_addr", imem_addr, mPc);
      checkOutput("model ifid_instruction", ifid_instruction, mInstr);
      checkOutput("model ifid_pc_plus4", ifid_pc_plus4, mP4);
      checkOutput("model ifid_valid", 32'(ifid_valid), 32'(mValid));
      checkOutput("model misaligned", 32'(misaligned), 32'(mMis));
      checkOutput("model fetch_state", 32'(fetch_state), 32'(mState));
    end
  end

  // Drive one cycle of inputs at a falling edge, return at the next falling edge.
  task automatic applyStimulus(input logic h, input logic br, input logic [31:0] tgt,
                               input logic j, input logic [25:0] idx,
                               input logic st, input logic fl);
    halt = h; branch_taken = br; branch_target = tgt;
    jump = j; jump_index = idx; stall = st; flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges, released at the following falling edge.
  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkIfid(input string name, input logic [31:0] instr, input logic [31:0] p4,
                           input logic v, input logic [31:0] pc);
    checkOutput({name, " instr"}, ifid_instruction, instr);
    checkOutput({name, " pc+4"}, ifid_pc_plus4, p4);
    checkOutput({name, " valid"}, 32'(ifid_valid), 32'(v));
    checkOutput({name, " pc"}, imem_addr, pc);
  endtask

  initial begin
    int n;
    logic [31:0] tgt;
    @(negedge clk);
    checkEn = 1'b1;
    checkIfid("reset", 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("reset misaligned", 32'(misaligned), 32'h0);
    checkOutput("reset state", 32'(fetch_state), 32'h0);
    rst_n = 1'b1;

    // Boot cycle then sequential fetch.
    idle();
    checkOutput("boot state", 32'(fetch_state), 32'h1);
    checkIfid("boot", 32'h0, 32'h0, 1'b0, 32'h0);
    idle(); checkIfid("fetch0", 32'h1000_0000, 32'd4, 1'b1, 32'd4);
    idle(); checkIfid("fetch1", 32'h1000_0001, 32'd8, 1'b1, 32'd8);
    idle(); checkIfid("fetch2", 32'h1000_0002, 32'd12, 1'b1, 32'd12);

    // Run up to the last word and wrap.
    n = 0;
    while (imem_addr != 32'd124 && n < 64) begin idle(); n++; end
    checkOutput("reach pc 124", imem_addr, 32'd124);
    idle(); checkIfid("wrap", 32'h1000_001F, 32'h0, 1'b1, 32'h0);
    idle(); checkIfid("after wrap", 32'h1000_0000, 32'd4, 1'b1, 32'd4);
    idle(); checkIfid("pc8", 32'h1000_0001, 32'd8, 1'b1, 32'd8);

    // Stall holds PC and IF/ID.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 1'b0);
      checkIfid("stall", 32'h1000_0001, 32'd8, 1'b1, 32'd8);
    end
    idle(); checkIfid("stall release", 32'h1000_0002, 32'd12, 1'b1, 32'd12);

    // Misaligned branch with concurrent stall.
    applyStimulus(1'b0, 1'b1, 32'h0000_0042, 1'b0, 26'h0, 1'b1, 1'b0);
    checkIfid("branch", 32'h0, 32'h0, 1'b0, 32'h40);
    checkOutput("branch misaligned", 32'(misaligned), 32'h1);

    // Jump from 0x10, then halt.
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 1'b0, 26'h0, 1'b0, 1'b0);
    checkOutput("branch to 0x10", imem_addr, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 26'h5, 1'b0, 1'b0);
    checkIfid("jump", 32'h0, 32'h0, 1'b0, 32'h14);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
    checkOutput("halt state", 32'(fetch_state), 32'h2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'(i % 2), 32'h0000_0020, 1'b0, 26'h0, 1'b0, 1'b0);
      checkOutput("halt frozen pc", imem_addr, 32'h14);
      checkOutput("halt frozen state", 32'(fetch_state), 32'h2);
    end

    // Reset out of halt, run, set misaligned, then reset between edges.
    pulseReset();
    idle(); idle(); idle();
    applyStimulus(1'b0, 1'b1, 32'h0000_0006, 1'b0, 26'h0, 1'b0, 1'b0);
    checkOutput("mid misaligned set", 32'(misaligned), 32'h1);
    idle(); checkIfid("pre reset", 32'h1000_0001, 32'd8, 1'b1, 32'd8);
    #2 rst_n = 1'b0;
    #1;
    checkIfid("async reset", 32'h0, 32'h0, 1'b0, RESET_PC);
    checkOutput("async reset misaligned", 32'(misaligned), 32'h0);
    checkOutput("async reset state", 32'(fetch_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); checkIfid("reboot", 32'h0, 32'h0, 1'b0, 32'h0);
    idle(); checkIfid("reboot fetch", 32'h1000_0000, 32'd4, 1'b1, 32'd4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ((mState == 2 && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) begin
        pulseReset();
      end else begin
        tgt = 32'($urandom_range(0, 40)) * 4;
        if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
        applyStimulus(1'($urandom_range(0, 199) == 0),
                      1'($urandom_range(0, 11) == 0), tgt,
                      1'($urandom_range(0, 11) == 0),
                      ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'($urandom_range(0, 35)),
                      1'($urandom_range(0, 4) == 0),
                      1'($urandom_range(0, 5) == 0));
      end
    end

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
